// File: rtl/aud_mode_counter_if.sv
// Control and status bundle for aud_mode_counter. Outputs are registered in
// the counter, so a master may sample them any time after the clock edge.
interface aud_mode_counter_if #(parameter int WIDTH = 8);
  logic             enable;
  logic             load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] value;
  logic             wrap;
  logic             dir;
  logic             done;

  modport master (
    output enable, load, mode, max,
    input  value, wrap, dir, done
  );

  modport slave (
    input  enable, load, mode, max,
    output value, wrap, dir, done
  );
endinterface

// File: rtl/aud_mode_counter.sv
// Multi-mode step counter (UP / DOWN / PINGPONG / ONESHOT) for the synth audio path.
// Mode and period are double-buffered and only change at reset, load or a wrap.
module aud_mode_counter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  aud_mode_counter_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_t            mode_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] value_q;
  logic             wrap_q;
  logic             dir_q;
  logic             done_q;

  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] step_value;
  logic             step_dir;
  logic             step_done;
  logic             wrap_evt;

  // max_q = 0 naturally yields TOP = all ones, i.e. a 2^WIDTH period.
  assign top = max_q - ONE;
  assign inc = value_q + ONE;
  assign dec = value_q - ONE;

  function automatic logic [WIDTH-1:0] start_of(input logic [1:0] m,
                                                input logic [WIDTH-1:0] mx);
    return (m == MODE_DOWN) ? (mx - ONE) : '0;
  endfunction

  always_comb begin
    step_value = value_q;
    step_dir   = dir_q;
    step_done  = done_q;
    wrap_evt   = 1'b0;
    case (mode_q)
      MODE_UP: begin
        if (value_q == top) wrap_evt = 1'b1;
        else                step_value = inc;
      end
      MODE_DOWN: begin
        if (value_q == '0) wrap_evt = 1'b1;
        else               step_value = dec;
      end
      MODE_PING: begin
        if (!dir_q) begin
          if (top == '0) begin
            wrap_evt = 1'b1;
          end else begin
            step_value = inc;
            step_dir   = (inc == top);
          end
        end else begin
          // Descent ends when the count would land on 0: that edge is the wrap.
          if (value_q == ONE || value_q == '0) wrap_evt = 1'b1;
          else                                 step_value = dec;
        end
      end
      MODE_ONESHOT: begin
        if (!done_q) begin
          if (value_q == top) begin
            step_done = 1'b1;
          end else begin
            step_value = inc;
            step_done  = (inc == top);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= mode_t'(bus.mode);
      max_q   <= bus.max;
    end else if (bus.load) begin
      mode_q  <= mode_t'(bus.mode);
      max_q   <= bus.max;
      value_q <= start_of(bus.mode, bus.max);
      dir_q   <= (bus.mode == MODE_DOWN);
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.enable) begin
      wrap_q <= wrap_evt;
      if (wrap_evt) begin
        mode_q  <= mode_t'(bus.mode);
        max_q   <= bus.max;
        value_q <= start_of(bus.mode, bus.max);
        dir_q   <= (bus.mode == MODE_DOWN);
      end else begin
        value_q <= step_value;
        dir_q   <= step_dir;
        done_q  <= step_done;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.value = value_q;
  assign bus.wrap  = wrap_q;
  assign bus.dir   = dir_q;
  assign bus.done  = done_q;

endmodule
